// File: rtl/tlp_pkg.sv
// Shared definitions for the TLP transmit path: width defaults, arbiter state
// encoding and the round-robin pointer increment.
package tlp_pkg;

  localparam int DOUBLE_WORD_DEF    = 32;
  localparam int HEADER_SIZE_DEF    = 4 * DOUBLE_WORD_DEF;
  localparam int TLP_DATA_WIDTH_DEF = 8 * DOUBLE_WORD_DEF;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  function automatic int mod_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request at or after ptr,
// searching upward and wrapping modulo N.
module rr_pick #(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    int j;
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    j      = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!any && req[j]) begin
        any       = 1'b1;
        onehot[j] = 1'b1;
        idx       = IW'(j);
      end
    end
  end

endmodule

// File: rtl/tlp_tx_arbiter.sv
// Packet-atomic round-robin arbiter sharing one TLP transmit interface among
// NUM_REQ sources, with a single registered output stage.
module tlp_tx_arbiter
  import tlp_pkg::*;
#(
  parameter int NUM_REQ        = 3,
  parameter int DOUBLE_WORD    = DOUBLE_WORD_DEF,
  parameter int HEADER_SIZE    = HEADER_SIZE_DEF,
  parameter int TLP_DATA_WIDTH = TLP_DATA_WIDTH_DEF
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_REQ*TLP_DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ*HEADER_SIZE-1:0]    req_hdr,
  input  logic [NUM_REQ-1:0]                req_sop,
  input  logic [NUM_REQ-1:0]                req_eop,
  input  logic [NUM_REQ-1:0]                req_valid,
  output logic [NUM_REQ-1:0]                req_ready,
  output logic [TLP_DATA_WIDTH-1:0]         out_data,
  output logic [HEADER_SIZE-1:0]            out_hdr,
  output logic                              out_sop,
  output logic                              out_eop,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [NUM_REQ-1:0]                grant,
  output logic                              busy,
  output logic                              proto_err
);

  localparam int IW = $clog2(NUM_REQ);

  logic [0:0]    state_reg;
  logic [IW-1:0] ptr_reg;
  logic [IW-1:0] owner_reg;
  logic          gap_reg;

  logic [TLP_DATA_WIDTH-1:0] data_arr [NUM_REQ];
  logic [HEADER_SIZE-1:0]    hdr_arr  [NUM_REQ];

  logic [NUM_REQ-1:0] pick_onehot;
  logic [IW-1:0]      pick_idx;
  logic               pick_any;

  logic          ld;
  logic [IW-1:0] sel;
  logic          sel_en;
  logic          accept;
  logic          beat_sop;
  logic          beat_eop;
  logic          fwd;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign data_arr[gi] = req_data[gi*TLP_DATA_WIDTH +: TLP_DATA_WIDTH];
      assign hdr_arr[gi]  = req_hdr[gi*HEADER_SIZE +: HEADER_SIZE];
    end
  endgenerate

  // Arbitrating over every valid requester (not only sop ones) lets a stray
  // beat win exactly when it sits ahead of all sop candidates in pointer order.
  rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .req    (req_valid),
    .ptr    (ptr_reg),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  assign ld   = !out_valid || out_ready;
  assign busy = (state_reg == ST_LOCKED);

  // The cycle after a packet end offers no ready, giving the dead cycle
  // between packets.
  always_comb begin
    sel    = owner_reg;
    sel_en = 1'b0;
    if (state_reg == ST_LOCKED) begin
      sel_en = 1'b1;
    end else if (!gap_reg && pick_any) begin
      sel    = pick_idx;
      sel_en = 1'b1;
    end
  end

  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_ready
      assign req_ready[gi] = rst_n && ld && sel_en && (sel == IW'(gi));
    end
  endgenerate

  assign accept   = rst_n && ld && sel_en && req_valid[sel];
  assign beat_sop = req_sop[sel];
  assign beat_eop = req_eop[sel];
  assign fwd      = accept && !((state_reg == ST_IDLE) && !beat_sop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      ptr_reg   <= '0;
      owner_reg <= '0;
      gap_reg   <= 1'b0;
      grant     <= '0;
      proto_err <= 1'b0;
      out_data  <= '0;
      out_hdr   <= '0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      gap_reg <= fwd && beat_eop;

      if (ld) begin
        out_valid <= fwd;
        if (fwd) begin
          out_data <= data_arr[sel];
          out_hdr  <= hdr_arr[sel];
          out_sop  <= beat_sop;
          out_eop  <= beat_eop;
        end
      end

      if (accept) begin
        if (state_reg == ST_IDLE) begin
          if (!beat_sop) begin
            proto_err <= 1'b1;
          end else begin
            grant <= pick_onehot;
            if (beat_eop) begin
              ptr_reg <= IW'(mod_inc(int'(sel), NUM_REQ));
            end else begin
              state_reg <= ST_LOCKED;
              owner_reg <= sel;
            end
          end
        end else begin
          if (beat_sop) proto_err <= 1'b1;
          if (beat_eop) begin
            state_reg <= ST_IDLE;
            ptr_reg   <= IW'(mod_inc(int'(owner_reg), NUM_REQ));
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_tlp_tx_arbiter.sv
// Directed bench for tlp_tx_arbiter: reset, single-beat, multi-beat round robin,
// backpressure, stray beats and mid-packet reset.
module tb_tlp_tx_arbiter;

  localparam int N  = 3;
  localparam int DW = 256;
  localparam int HW = 128;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N*DW-1:0] req_data;
  logic [N*HW-1:0] req_hdr;
  logic [N-1:0]    req_sop, req_eop, req_valid, req_ready;
  logic [DW-1:0]   out_data;
  logic [HW-1:0]   out_hdr;
  logic            out_sop, out_eop, out_valid, out_ready;
  logic [N-1:0]    grant;
  logic            busy, proto_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  tlp_tx_arbiter #(.NUM_REQ(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_data  (req_data),
    .req_hdr   (req_hdr),
    .req_sop   (req_sop),
    .req_eop   (req_eop),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .out_data  (out_data),
    .out_hdr   (out_hdr),
    .out_sop   (out_sop),
    .out_eop   (out_eop),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .grant     (grant),
    .busy      (busy),
    .proto_err (proto_err)
  );

  function automatic logic [DW-1:0] mkdata(input int i, input logic s, input logic e);
    return {224'h0, 16'hDA7A, 8'(i), 6'h0, s, e};
  endfunction

  function automatic logic [HW-1:0] mkhdr(input int i);
    return {96'h0, 16'hBEEF, 16'(i)};
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [N-1:0] v, input logic [N-1:0] s, input logic [N-1:0] e);
    for (int i = 0; i < N; i++) begin
      req_valid[i]         = v[i];
      req_sop[i]           = s[i];
      req_eop[i]           = e[i];
      req_data[i*DW +: DW] = mkdata(i, s[i], e[i]);
      req_hdr[i*HW +: HW]  = mkhdr(i);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ready(input string tag, input logic [N-1:0] exp);
    #1;
    chk(tag, req_ready, exp);
  endtask

  task automatic chk_beat(input string tag, input int r, input logic s, input logic e);
    chk({tag, ".valid"}, out_valid, 1'b1);
    chk({tag, ".data"}, out_data, mkdata(r, s, e));
    chk({tag, ".hdr"}, out_hdr, mkhdr(r));
    chk({tag, ".sop"}, out_sop, s);
    chk({tag, ".eop"}, out_eop, e);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive('0, '0, '0);
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset: ready must stay low even with every requester asking
    rst_n     = 1'b0;
    out_ready = 1'b1;
    drive(3'b111, 3'b111, 3'b111);
    chk_ready("rst.ready", 3'b000);
    tick();
    tick();
    chk("rst.valid", out_valid, 1'b0);
    chk("rst.grant", grant, 3'b000);
    chk("rst.busy", busy, 1'b0);
    chk("rst.err", proto_err, 1'b0);
    chk("rst.sop", out_sop, 1'b0);
    chk("rst.eop", out_eop, 1'b0);
    chk("rst.data", out_data, 256'h0);
    rst_n = 1'b1;
    drive('0, '0, '0);

    // 1: single-beat TLP from requester 0
    req_valid = 3'b001;
    req_sop   = 3'b001;
    req_eop   = 3'b001;
    req_data  = '0;
    req_data[255:0] = 256'hA5;
    req_hdr   = '0;
    req_hdr[127:0]  = 128'h4000_0000_0000_0000_0000_0000_0000_0001;
    chk_ready("t1.ready", 3'b001);
    chk("t1.pre_valid", out_valid, 1'b0);
    tick();
    chk("t1.valid", out_valid, 1'b1);
    chk("t1.hdr", out_hdr, 128'h4000_0000_0000_0000_0000_0000_0000_0001);
    chk("t1.data", out_data, 256'hA5);
    chk("t1.sop", out_sop, 1'b1);
    chk("t1.eop", out_eop, 1'b1);
    chk("t1.grant", grant, 3'b001);
    chk("t1.busy", busy, 1'b0);
    drive('0, '0, '0);
    tick();
    chk("t1.after_valid", out_valid, 1'b0);
    chk("t1.after_busy", busy, 1'b0);

    // 2: three 2-beat TLPs at once -> 0,0,dead,1,1,dead,2,2
    do_reset();
    drive(3'b111, 3'b111, 3'b000);
    chk_ready("t2.r0", 3'b001);
    tick();
    chk_beat("t2.b00", 0, 1'b1, 1'b0);
    chk("t2.busy0", busy, 1'b1);
    chk("t2.grant0", grant, 3'b001);
    drive(3'b111, 3'b110, 3'b001);
    chk_ready("t2.r1", 3'b001);
    tick();
    chk_beat("t2.b01", 0, 1'b0, 1'b1);
    chk("t2.busy1", busy, 1'b0);
    drive(3'b110, 3'b110, 3'b000);
    chk_ready("t2.gap1", 3'b000);
    tick();
    chk("t2.dead1", out_valid, 1'b0);
    chk_ready("t2.r2", 3'b010);
    tick();
    chk_beat("t2.b10", 1, 1'b1, 1'b0);
    chk("t2.busy2", busy, 1'b1);
    chk("t2.grant1", grant, 3'b010);
    drive(3'b110, 3'b100, 3'b010);
    chk_ready("t2.r3", 3'b010);
    tick();
    chk_beat("t2.b11", 1, 1'b0, 1'b1);
    drive(3'b100, 3'b100, 3'b000);
    chk_ready("t2.gap2", 3'b000);
    tick();
    chk("t2.dead2", out_valid, 1'b0);
    chk_ready("t2.r4", 3'b100);
    tick();
    chk_beat("t2.b20", 2, 1'b1, 1'b0);
    chk("t2.grant2", grant, 3'b100);
    drive(3'b100, 3'b000, 3'b100);
    chk_ready("t2.r5", 3'b100);
    tick();
    chk_beat("t2.b21", 2, 1'b0, 1'b1);
    chk("t2.busy3", busy, 1'b0);
    drive('0, '0, '0);
    tick();
    chk("t2.end_valid", out_valid, 1'b0);

    // 3: requesters 0 and 2 stream single-beat TLPs, must alternate
    do_reset();
    drive(3'b101, 3'b101, 3'b101);
    for (int p = 0; p < 8; p++) begin
      chk_ready($sformatf("t3.ready%0d", p), (p % 2 == 0) ? 3'b001 : 3'b100);
      tick();
      chk_beat($sformatf("t3.pkt%0d", p), (p % 2 == 0) ? 0 : 2, 1'b1, 1'b1);
      chk($sformatf("t3.grant%0d", p), grant, (p % 2 == 0) ? 3'b001 : 3'b100);
      chk_ready($sformatf("t3.gap%0d", p), 3'b000);
      tick();
      chk($sformatf("t3.dead%0d", p), out_valid, 1'b0);
    end
    drive('0, '0, '0);

    // 4: 3-beat TLP from requester 1 with 5 cycles of backpressure
    do_reset();
    drive(3'b010, 3'b010, 3'b000);
    chk_ready("t4.r0", 3'b010);
    tick();
    chk_beat("t4.b0", 1, 1'b1, 1'b0);
    out_ready = 1'b0;
    drive(3'b010, 3'b000, 3'b000);
    for (int k = 0; k < 5; k++) begin
      chk_ready($sformatf("t4.stall_ready%0d", k), 3'b000);
      tick();
      chk_beat($sformatf("t4.hold%0d", k), 1, 1'b1, 1'b0);
      chk($sformatf("t4.hold_grant%0d", k), grant, 3'b010);
    end
    out_ready = 1'b1;
    chk_ready("t4.r1", 3'b010);
    tick();
    chk_beat("t4.b1", 1, 1'b0, 1'b0);
    chk("t4.busy", busy, 1'b1);
    drive(3'b010, 3'b000, 3'b010);
    chk_ready("t4.r2", 3'b010);
    tick();
    chk_beat("t4.b2", 1, 1'b0, 1'b1);
    chk("t4.busy_end", busy, 1'b0);
    drive('0, '0, '0);
    tick();
    chk("t4.end_valid", out_valid, 1'b0);

    // 5: stray beat (valid without sop) from requester 2 in IDLE
    do_reset();
    drive(3'b100, 3'b000, 3'b000);
    chk_ready("t5.ready", 3'b100);
    tick();
    chk("t5.valid", out_valid, 1'b0);
    chk("t5.err", proto_err, 1'b1);
    chk("t5.grant", grant, 3'b000);
    chk("t5.busy", busy, 1'b0);
    drive('0, '0, '0);
    chk_ready("t5.ready_off", 3'b000);
    tick();
    tick();
    chk("t5.err_sticky", proto_err, 1'b1);
    rst_n = 1'b0;
    tick();
    chk("t5.err_cleared", proto_err, 1'b0);
    rst_n = 1'b1;

    // 6: reset during beat 2 of a 4-beat packet; pointer must restart at 0
    do_reset();
    drive(3'b010, 3'b010, 3'b010);
    chk_ready("t6.pre_ready", 3'b010);
    tick();
    chk_beat("t6.pre", 1, 1'b1, 1'b1);
    drive('0, '0, '0);
    tick();
    drive(3'b100, 3'b100, 3'b000);
    chk_ready("t6.r0", 3'b100);
    tick();
    chk_beat("t6.b0", 2, 1'b1, 1'b0);
    chk("t6.busy", busy, 1'b1);
    chk("t6.grant", grant, 3'b100);
    drive(3'b100, 3'b000, 3'b000);
    rst_n = 1'b0;
    chk_ready("t6.rst_ready", 3'b000);
    tick();
    chk("t6.rst_valid", out_valid, 1'b0);
    chk("t6.rst_data", out_data, 256'h0);
    chk("t6.rst_hdr", out_hdr, 256'h0);
    chk("t6.rst_sop", out_sop, 1'b0);
    chk("t6.rst_eop", out_eop, 1'b0);
    chk("t6.rst_grant", grant, 3'b000);
    chk("t6.rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    drive(3'b110, 3'b110, 3'b110);
    chk_ready("t6.after_ready", 3'b010);
    tick();
    chk_beat("t6.after", 1, 1'b1, 1'b1);
    chk("t6.after_grant", grant, 3'b010);
    chk("t6.after_busy", busy, 1'b0);
    drive('0, '0, '0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tlp_tx_arbiter.md
Name: tlp_tx_arbiter

Overview:
- Shares one TLP transmit interface (data/hdr/sop/eop/valid/ready) among NUM_REQ requesters, e.g. posted-write, completion and read-request generators.
- Packet-atomic round-robin arbitration: a grant is held from the sop beat through the eop beat, so TLPs never interleave.
- Sits between the TLP sources and the TX link-layer input.
- All output signals are driven from a single registered output stage.

Parameters:
- NUM_REQ, 3, number of requesters (2..8)
- DOUBLE_WORD, 32, double-word width in bits
- HEADER_SIZE, 4*DOUBLE_WORD, TLP header width (4DW header)
- TLP_DATA_WIDTH, 8*DOUBLE_WORD, data payload width per beat

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- req_data  in  NUM_REQ*TLP_DATA_WIDTH  per-requester beat data; requester i occupies slice [i*TLP_DATA_WIDTH +: TLP_DATA_WIDTH]
- req_hdr  in  NUM_REQ*HEADER_SIZE  per-requester header; meaningful on sop beats
- req_sop  in  NUM_REQ  start of packet
- req_eop  in  NUM_REQ  end of packet
- req_valid  in  NUM_REQ  beat valid
- req_ready  out  NUM_REQ  beat accepted when valid&ready
- out_data  out  TLP_DATA_WIDTH  arbitrated beat data
- out_hdr  out  HEADER_SIZE  arbitrated header
- out_sop  out  1  start of packet
- out_eop  out  1  end of packet
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accept
- grant  out  NUM_REQ  one-hot owner of the current or last packet; 0 after reset
- busy  out  1  high in LOCKED state
- proto_err  out  1  sticky protocol-error flag; cleared only by reset

Behaviour:
- Reset (rst_n=0 at posedge clk):
  - All outputs go to 0: out_*, grant, busy, proto_err, and req_ready combinationally.
  - State returns to IDLE and the round-robin pointer returns to 0.
  - Reset mid-packet discards the partial packet; no eop is generated.
- Output stage load enable: ld = !out_valid | out_ready.
  - When a beat is accepted, out_* take the accepted requester's slices at the next edge; latency is 1 cycle.
  - If ld=1 and no beat is accepted, out_valid <= 0.
  - If ld=0, all out_* hold stable.
- FSM state IDLE:
  - Candidates are requesters with req_valid & req_sop.
  - Winner is the first candidate at or after ptr, searching upward modulo NUM_REQ.
  - req_ready[winner] = ld; all other req_ready bits are 0.
  - On accept with eop=1 (single-beat TLP): stay in IDLE and set ptr <= winner+1 mod NUM_REQ.
  - On accept with eop=0: go to LOCKED and set owner <= winner.
  - grant <= onehot(winner) on accept.
- FSM state LOCKED:
  - req_ready[owner] = ld; all other req_ready bits are 0.
  - On an accepted eop beat: go to IDLE and set ptr <= owner+1 mod NUM_REQ.
  - An accepted beat from the owner with sop=1 sets proto_err; the beat is still forwarded unchanged.
- Requester holding valid without sop while in IDLE:
  - If it would win over all sop-candidates under the pointer order, it receives req_ready=ld, its beat is dropped (not forwarded), and proto_err is set.
  - Otherwise it waits.
  - This prevents deadlock on stray beats.
- Simultaneous events:
  - An eop accept and a new sop request in the same cycle: the new sop is arbitrated the following cycle. There is one dead cycle minimum between packets from different requesters.
  - out_ready toggling mid-packet never changes the owner.
- Invariants:
  - At most one req_ready bit is high.
  - A beat is never duplicated or lost while rst_n=1, except stray dropped beats.

Decomposition:
- Shared package tlp_pkg holds:
  - DOUBLE_WORD, HEADER_SIZE and TLP_DATA_WIDTH defaults
  - the arbiter FSM state encoding (IDLE=1'b0, LOCKED=1'b1)
  - a function for the modulo-NUM_REQ increment
- One sub-module, rr_pick: combinational round-robin selector.
  - Inputs: req vector, ptr.
  - Outputs: one-hot winner, index, any.
  - Reusable by the RX-side completion scheduler.

Test Plan:
1. Requester 0 sends a single-beat TLP (sop=eop=1, hdr=128'h4000_0000_..._0001, data=256'hA5) with out_ready=1 → out_valid=1 exactly one cycle later with identical hdr/data and sop=eop=1; grant=3'b001; busy stays 0.
2. After reset, requesters 0, 1 and 2 each present a 2-beat TLP simultaneously → output order is 0,0,1,1,2,2; no interleaving; busy=1 on first beats; total 6 beats plus 2 dead cycles.
3. Requesters 0 and 2 send single-beat TLPs continuously → output alternates 0,2,0,2 for 8 packets; requester 1 idle never granted.
4. A 3-beat packet from requester 1 with out_ready=0 for 5 cycles after beat 1 → out_* held stable; req_ready=0 throughout; beats 2 and 3 delivered in order after release.
5. Requester 2 presents valid without sop in IDLE with no other requests → req_ready[2]=1 for one cycle; out_valid stays 0; proto_err=1 and remains 1 until rst_n=0.
6. rst_n pulsed low during beat 2 of a 4-beat packet → next cycle all outputs are 0 and state is IDLE; a subsequent TLP from requester 1 is granted normally (ptr=0 order).
